trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 47 ++++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/trace_capture.sv | 128 ++++++++++++
 tb/tb_trace_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared state encoding, record width and opcode classification for the
// retire trace capture block.
package trace_pkg;

    localparam int REC_W = 46;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_BAD = 2'd3
    } op_class_t;

    localparam logic [5:0] OP_R_LAST = 6'b000101;
    localparam logic [5:0] OP_R_EXT0 = 6'b001111;
    localparam logic [5:0] OP_R_EXT1 = 6'b011000;
    localparam logic [5:0] OP_I_LO0  = 6'b000110;
    localparam logic [5:0] OP_I_HI0  = 6'b001110;
    localparam logic [5:0] OP_I_LO1  = 6'b010000;
    localparam logic [5:0] OP_I_HI1  = 6'b010101;
    localparam logic [5:0] OP_J0     = 6'b010110;
    localparam logic [5:0] OP_J1     = 6'b010111;

    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t c;
        c = CLS_BAD;
        if (op <= OP_R_LAST || op == OP_R_EXT0 || op == OP_R_EXT1)
            c = CLS_R;
        else if ((op >= OP_I_LO0 && op <= OP_I_HI0) || (op >= OP_I_LO1 && op <= OP_I_HI1))
            c = CLS_I;
        else if (op == OP_J0 || op == OP_J1)
            c = CLS_J;
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer; with i_ovw set, a push into a full buffer
// replaces the oldest entry instead of being refused.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = REC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_ovw,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full,
    output logic [6:0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [6:0]    r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_ovw;

    assign w_full = (r_count == 7'(DEPTH));
    assign w_pop  = i_pop && (r_count != 7'd0);
    // Overwrite advances the read pointer in place of a pop, so count holds.
    assign w_ovw  = i_push && w_full && !w_pop && i_ovw;
    assign w_wr   = i_push && (!w_full || w_pop || i_ovw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wr <= r_wr + 1'b1;
            if (w_pop || w_ovw)
                r_rd <= r_rd + 1'b1;
            if (w_wr && !w_pop && !w_ovw)
                r_count <= r_count + 7'd1;
            else if (w_pop && !w_wr)
                r_count <= r_count - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush)
            r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_count != 7'd0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/trace_capture.sv
// Retire trace capture: arm/trigger/post-count FSM, per-class retire
// counters and drop accounting around a circular record buffer.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic [7:0]       pc,
    input  logic [5:0]       opcode,
    input  logic [31:0]      result,
    input  logic             arm,
    input  logic             clear,
    input  logic [5:0]       trig_opcode,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_data,
    output logic [6:0]       occupancy,
    output logic [1:0]       state,
    output logic [15:0]      cnt_r,
    output logic [15:0]      cnt_i,
    output logic [15:0]      cnt_j,
    output logic [15:0]      cnt_bad,
    output logic [15:0]      drop_cnt
);
    state_t    r_state;
    state_t    w_next;
    logic [7:0]  r_post;
    logic [15:0] r_cnt_r;
    logic [15:0] r_cnt_i;
    logic [15:0] r_cnt_j;
    logic [15:0] r_cnt_bad;
    logic [15:0] r_drop;
    logic      w_active;
    logic      w_flush;
    logic      w_cap;
    logic      w_trig;
    logic      w_pop;
    logic      w_full;
    logic      w_push;
    logic      w_ovw;
    logic      w_drop;
    op_class_t w_cls;

    assign w_active = (r_state == ST_ARMED) || (r_state == ST_POST);
    // arm only restarts capture from a quiescent state; clear always flushes.
    assign w_flush  = clear || (arm && (r_state == ST_IDLE || r_state == ST_FROZEN));
    assign w_cap    = retire && w_active && !clear;
    assign w_trig   = w_cap && (r_state == ST_ARMED) && (opcode == trig_opcode);
    assign w_pop    = rd_valid && rd_ready;
    assign w_cls    = op_class(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_FROZEN: if (arm) w_next = ST_ARMED;
                ST_ARMED: if (w_trig) w_next = (POST_CNT == 0) ? ST_FROZEN : ST_POST;
                ST_POST:  if (w_cap && r_post == 8'd1) w_next = ST_FROZEN;
                default:  w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_push = w_cap;
        w_ovw  = (r_state == ST_ARMED);
        w_drop = (r_state == ST_POST) && w_cap && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_flush) begin
            r_post    <= '0;
            r_cnt_r   <= '0;
            r_cnt_i   <= '0;
            r_cnt_j   <= '0;
            r_cnt_bad <= '0;
            r_drop    <= '0;
        end else begin
            if (w_trig)
                r_post <= 8'(POST_CNT);
            else if (w_cap && r_state == ST_POST)
                r_post <= r_post - 8'd1;
            if (w_cap) begin
                case (w_cls)
                    CLS_R:   r_cnt_r   <= sat_inc(r_cnt_r);
                    CLS_I:   r_cnt_i   <= sat_inc(r_cnt_i);
                    CLS_J:   r_cnt_j   <= sat_inc(r_cnt_j);
                    default: r_cnt_bad <= sat_inc(r_cnt_bad);
                endcase
            end
            if (w_drop)
                r_drop <= sat_inc(r_drop);
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_ovw   (w_ovw),
        .i_pop   (w_pop),
        .i_data  ({pc, opcode, result}),
        .o_data  (rd_data),
        .o_valid (rd_valid),
        .o_full  (w_full),
        .o_count (occupancy)
    );

    assign state    = r_state;
    assign cnt_r    = r_cnt_r;
    assign cnt_i    = r_cnt_i;
    assign cnt_j    = r_cnt_j;
    assign cnt_bad  = r_cnt_bad;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: table of cycle vectors with hand expectations,
// hand sequences for overwrite/drop/reset, and a record scoreboard.
module tb_trace_capture;
    localparam int DEPTH = 16;
    localparam int PCNT  = 2;
    localparam logic [5:0] TRIG = 6'b010011;
    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] ADDI = 6'b000110;
    localparam logic [5:0] JMP  = 6'b010110;
    localparam logic [5:0] BAD  = 6'b011111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        retire = 1'b0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        rd_ready = 1'b0;
    logic [7:0]  pc = '0;
    logic [5:0]  opcode = '0;
    logic [5:0]  trig_opcode = TRIG;
    logic [31:0] result = '0;
    logic        rd_valid;
    logic [45:0] rd_data;
    logic [6:0]  occupancy;
    logic [1:0]  state;
    logic [15:0] cnt_r, cnt_i, cnt_j, cnt_bad, drop_cnt;

    trace_capture #(.DEPTH(DEPTH), .POST_CNT(PCNT)) dut (
        .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc), .opcode(opcode),
        .result(result), .arm(arm), .clear(clear), .trig_opcode(trig_opcode),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .occupancy(occupancy), .state(state), .cnt_r(cnt_r), .cnt_i(cnt_i),
        .cnt_j(cnt_j), .cnt_bad(cnt_bad), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [45:0] q[$];
    logic [1:0]  m_state = 2'd0;
    int          m_post = 0;
    logic [15:0] m_cnt[4];
    logic [15:0] m_drop = '0;

    typedef struct {
        logic       ret;
        logic [7:0] pc;
        logic [5:0] op;
        logic       rdy, a, c;
        logic [1:0] st;
        int         occ, r, i, j, b;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        int v;
        v = int'(op);
        if (v > 24) return 3;
        if (v == 22 || v == 23) return 2;
        if ((v >= 6 && v <= 14) || (v >= 16 && v <= 21)) return 1;
        return 0;
    endfunction

    // One clock of stimulus; the reference model advances at the edge.
    task automatic cyc(input logic ret, input logic [7:0] p, input logic [5:0] op,
                       input logic rdy, input logic a, input logic c);
        logic [45:0] rec;
        bit pop, flush, cap;
        @(negedge clk);
        retire = ret; pc = p; opcode = op; rd_ready = rdy; arm = a; clear = c;
        result = {p, ~p, 10'h15A, op};
        #1;
        chk("rd_valid", rd_valid, q.size() != 0);
        pop = rdy && q.size() != 0;
        if (pop) chk("rd_data", rd_data, q[0]);
        rec   = {p, op, result};
        flush = c || (a && (m_state == 2'd0 || m_state == 2'd3));
        cap   = ret && !c && (m_state == 2'd1 || m_state == 2'd2);
        @(posedge clk);
        if (flush) begin
            q.delete();
            foreach (m_cnt[k]) m_cnt[k] = '0;
            m_drop = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (m_cnt[cls(op)] != 16'hFFFF) m_cnt[cls(op)]++;
                if (q.size() < DEPTH) q.push_back(rec);
                else if (m_state == 2'd1) begin
                    void'(q.pop_front());
                    q.push_back(rec);
                end else if (m_drop != 16'hFFFF) m_drop++;
            end
        end
        if (c) m_state = 2'd0;
        else if ((m_state == 2'd0 || m_state == 2'd3) && a) m_state = 2'd1;
        else if (m_state == 2'd1 && cap && op == trig_opcode) begin
            m_post  = PCNT;
            m_state = (PCNT == 0) ? 2'd3 : 2'd2;
        end else if (m_state == 2'd2 && cap) begin
            m_post--;
            if (m_post == 0) m_state = 2'd3;
        end
        #1;
        chk("state", state, m_state);
        chk("occupancy", occupancy, q.size());
        chk("drop_cnt", drop_cnt, m_drop);
        retire = 0; arm = 0; clear = 0; rd_ready = 0;
    endtask

    initial begin
        foreach (m_cnt[k]) m_cnt[k] = '0;
        tbl[0]  = '{1'b0, 8'h00, ADD,  1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 8'h10, ADD,  1'b0, 1'b0, 1'b0, 2'd1, 1, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 8'h11, ADDI, 1'b0, 1'b0, 1'b0, 2'd1, 2, 1, 1, 0, 0};
        tbl[3]  = '{1'b1, 8'h12, JMP,  1'b0, 1'b0, 1'b0, 2'd1, 3, 1, 1, 1, 0};
        tbl[4]  = '{1'b0, 8'h00, ADD,  1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 8'h00, ADD,  1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0, 0, 0};
        tbl[6]  = '{1'b1, 8'h20, TRIG, 1'b0, 1'b0, 1'b0, 2'd2, 1, 0, 1, 0, 0};
        tbl[7]  = '{1'b1, 8'h21, ADD,  1'b0, 1'b0, 1'b0, 2'd2, 2, 1, 1, 0, 0};
        tbl[8]  = '{1'b1, 8'h22, ADDI, 1'b0, 1'b0, 1'b0, 2'd3, 3, 1, 2, 0, 0};
        tbl[9]  = '{1'b1, 8'h23, JMP,  1'b0, 1'b0, 1'b0, 2'd3, 3, 1, 2, 0, 0};
        tbl[10] = '{1'b0, 8'h00, ADD,  1'b1, 1'b0, 1'b0, 2'd3, 2, 1, 2, 0, 0};
        tbl[11] = '{1'b0, 8'h00, ADD,  1'b1, 1'b0, 1'b0, 2'd3, 1, 1, 2, 0, 0};
        tbl[12] = '{1'b0, 8'h00, ADD,  1'b1, 1'b0, 1'b0, 2'd3, 0, 1, 2, 0, 0};
        tbl[13] = '{1'b0, 8'h00, ADD,  1'b1, 1'b0, 1'b0, 2'd3, 0, 1, 2, 0, 0};
        tbl[14] = '{1'b0, 8'h00, ADD,  1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0, 0, 0};
        tbl[15] = '{1'b1, 8'h30, BAD,  1'b0, 1'b0, 1'b0, 2'd1, 1, 0, 0, 0, 1};
        tbl[16] = '{1'b1, 8'h31, ADD,  1'b0, 1'b1, 1'b1, 2'd0, 0, 0, 0, 0, 0};
        tbl[17] = '{1'b1, 8'h32, ADD,  1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 0};
        tbl[18] = '{1'b0, 8'h00, ADD,  1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0, 0, 0};

        #1 rst_n = 1'b0;
        #11;
        chk("rst state", state, 2'd0);
        chk("rst occupancy", occupancy, 7'd0);
        chk("rst rd_valid", rd_valid, 1'b0);
        chk("rst rd_data", rd_data, 46'd0);
        chk("rst cnt_r", cnt_r, 16'd0);
        chk("rst cnt_bad", cnt_bad, 16'd0);
        chk("rst drop_cnt", drop_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 19; k++) begin
            cyc(tbl[k].ret, tbl[k].pc, tbl[k].op, tbl[k].rdy, tbl[k].a, tbl[k].c);
            chk($sformatf("v%0d state", k), state, tbl[k].st);
            chk($sformatf("v%0d occupancy", k), occupancy, tbl[k].occ);
            chk($sformatf("v%0d cnt_r", k), cnt_r, tbl[k].r);
            chk($sformatf("v%0d cnt_i", k), cnt_i, tbl[k].i);
            chk($sformatf("v%0d cnt_j", k), cnt_j, tbl[k].j);
            chk($sformatf("v%0d cnt_bad", k), cnt_bad, tbl[k].b);
        end

        // ARMED overwrite: 20 retires into a 16-deep buffer
        for (int k = 0; k < 20; k++) cyc(1'b1, 8'h40 + 8'(k), ADD, 1'b0, 1'b0, 1'b0);
        chk("ovw occupancy", occupancy, 7'd16);
        chk("ovw head pc", rd_data[45:38], 8'h44);
        chk("ovw drop_cnt", drop_cnt, 16'd0);
        chk("ovw cnt_r", cnt_r, 16'd20);

        // POST with full buffer and no consumer: both records dropped
        cyc(1'b1, 8'h60, TRIG, 1'b0, 1'b0, 1'b0);
        chk("post trig state", state, 2'd2);
        cyc(1'b1, 8'h61, ADD, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h62, ADD, 1'b0, 1'b0, 1'b0);
        chk("post full drop_cnt", drop_cnt, 16'd2);
        chk("post full state", state, 2'd3);
        chk("post full occupancy", occupancy, 7'd16);

        // Same again with a consumer: push and pop together, nothing dropped
        cyc(1'b0, 8'h00, ADD, 1'b0, 1'b1, 1'b0);
        chk("rearm drop_cnt", drop_cnt, 16'd0);
        for (int k = 0; k < 16; k++) cyc(1'b1, 8'h70 + 8'(k), ADD, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h80, TRIG, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h81, ADD, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h82, ADD, 1'b1, 1'b0, 1'b0);
        chk("pushpop drop_cnt", drop_cnt, 16'd0);
        chk("pushpop occupancy", occupancy, 7'd16);
        chk("pushpop state", state, 2'd3);
        chk("pushpop head pc", rd_data[45:38], 8'h73);
        for (int k = 0; k < 16; k++) cyc(1'b0, 8'h00, ADD, 1'b1, 1'b0, 1'b0);
        chk("drained occupancy", occupancy, 7'd0);

        // Asynchronous reset in the middle of POST
        cyc(1'b0, 8'h00, ADD, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h90, TRIG, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h91, ADD, 1'b0, 1'b0, 1'b0);
        chk("pre-reset state", state, 2'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst state", state, 2'd0);
        chk("mid rst occupancy", occupancy, 7'd0);
        chk("mid rst rd_valid", rd_valid, 1'b0);
        chk("mid rst rd_data", rd_data, 46'd0);
        chk("mid rst cnt_r", cnt_r, 16'd0);
        chk("mid rst cnt_i", cnt_i, 16'd0);
        chk("mid rst drop_cnt", drop_cnt, 16'd0);
        q.delete();
        foreach (m_cnt[k]) m_cnt[k] = '0;
        m_drop = '0; m_state = 2'd0; m_post = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'hA0, ADD, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, TRIG, 1'b0, 1'b0, 1'b0);
        chk("post-rst state", state, 2'd0);
        chk("post-rst occupancy", occupancy, 7'd0);
        chk("post-rst cnt_r", cnt_r, 16'd0);
        cyc(1'b0, 8'h00, ADD, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hB0, ADD, 1'b0, 1'b0, 1'b0);
        chk("rearmed occupancy", occupancy, 7'd1);
        cyc(1'b0, 8'h00, ADD, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
